axil_write_ctrl_slave: RTL and testbench
========================================

Name: axil_write_ctrl_slave

Overview:
AXI4-Lite slave write-side controller. Sits directly upstream of the write-response stage and produces the BVALID/BRESP that stage consumes.
- Accepts the AW and W channels independently, in either order or the same cycle, and joins them.
- Issues one write pulse to the register bank.
- Generates the B response and holds it until BREADY.

Parameters:
ADDR_WIDTH, 8, AWADDR width in bits (byte address).
DATA_WIDTH, 32, WDATA width in bits; WSTRB is DATA_WIDTH/8 bits.
NUM_REGS, 16, number of 32-bit words in the register bank; word index = AWADDR[ADDR_WIDTH-1:2].

Ports:
ACLK  in  1  clock; all logic on its rising edge.
ARESETn  in  1  synchronous, active-high reset: reset is applied when ARESETn==1 at a rising edge of ACLK.
AWADDR  in  ADDR_WIDTH  write address.
AWVALID  in  1  address valid.
AWREADY  out  1  address ready.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte strobes.
WVALID  in  1  data valid.
WREADY  out  1  data ready.
BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
BVALID  out  1  response valid.
BREADY  in  1  response ready.
reg_wr_en  out  1  one-cycle write strobe to the register bank.
reg_wr_addr  out  ADDR_WIDTH-2  word index.
reg_wr_data  out  DATA_WIDTH  write data.
reg_wr_strb  out  DATA_WIDTH/8  byte enables.

Behaviour:
Reset values:
- AWREADY=0, WREADY=0 while reset is asserted.
- BVALID=0, BRESP=00, reg_wr_en=0, reg_wr_addr/data/strb=0.
- aw_full=0, w_full=0, state=COLLECT.
- Any in-flight transaction is dropped; no register write and no response are issued for it.

States: COLLECT, WRITE, RESP. Two-bit encoding, registered.

COLLECT:
- AWREADY = !aw_full. WREADY = !w_full. Both are combinational from registered state/flags only, never from AWVALID/WVALID.
- On AWVALID&&AWREADY: latch AWADDR, set aw_full.
- On WVALID&&WREADY: latch WDATA/WSTRB, set w_full.
- When the edge leaves both flags set (same-cycle or second handshake), the next state is WRITE.
- The response code is registered at that same edge:
  - SLVERR if AWADDR[1:0]!=0 or word index >= NUM_REGS.
  - OKAY otherwise.
- One channel may wait indefinitely for the other. Its READY stays low once captured; a second beat on that channel is not accepted.

WRITE (exactly 1 cycle):
- AWREADY=WREADY=0.
- reg_wr_en=1 only if the response code is OKAY. WSTRB=0 still pulses reg_wr_en, with strb 0.
- reg_wr_addr/data/strb carry the latched values, held stable in all states until the next capture.
- Next state is RESP.

RESP:
- BVALID=1, BRESP=registered code; both stable until handshake.
- AWREADY=WREADY=0.
- On BVALID&&BREADY: clear aw_full/w_full, go to COLLECT; BVALID=0 from the next cycle.
- BREADY may be high before BVALID; the handshake then completes on the first RESP edge.

Latency:
- Final AW/W handshake at edge N: reg_wr_en high between edges N and N+1; BVALID high from edge N+1.
- With BREADY=1, the B handshake occurs at edge N+2 and AWREADY/WREADY are high again after N+2.
- Best-case throughput: 1 write per 3 cycles.

Reset mid-operation: reset at any state returns to reset values at that edge. If reset is asserted during WRITE, reg_wr_en drops that same edge; no BVALID follows.

Decomposition:
Shared package/include axil_pkg holds:
- RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- State encodings S_COLLECT/S_WRITE/S_RESP.

One natural sub-module, axil_chan_capture: a one-entry valid/ready holding register (payload width parameter, full flag, ready=!full, external clear). It is instantiated twice, once for AW (payload AWADDR) and once for W (payload {WSTRB,WDATA}). The FSM, decode and B logic live in the top.

Test Plan:
1. AW (AWADDR=0x08) and W (WDATA=0xDEADBEEF, WSTRB=0xF) valid at the same edge N, BREADY=1 -> reg_wr_en=1 for one cycle with addr=2, data=0xDEADBEEF, strb=0xF; BVALID=1, BRESP=00 from N+1; handshake at N+2; AWREADY=WREADY=1 after N+2.
2. W first (0x12345678) at edge N, AW (0x04) 5 cycles later -> WREADY=0 after N while AWREADY stays 1; write to addr 1 occurs one cycle after the AW handshake; BRESP=00.
3. AWADDR=0x40 (index 16, NUM_REGS=16) and AWADDR=0x05 (misaligned), each as a separate transaction -> reg_wr_en never asserts; BVALID with BRESP=10 for each.
4. BREADY held 0 for 10 cycles after BVALID -> BVALID/BRESP stable throughout; AWREADY=WREADY=0 while a new AWVALID/WVALID is presented; new transaction accepted only after the B handshake.
5. ARESETn=1 asserted during WRITE, then during RESP -> outputs return to reset values at that edge; no BVALID; after release a fresh write completes normally with BRESP=00.
6. 8 back-to-back writes with AW/W/B valid/ready always high -> exactly 8 reg_wr_en pulses, one every 3 cycles, addresses/data in order, 8 OKAY responses.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and write-controller states.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_COLLECT = 2'b00,
    S_WRITE   = 2'b01,
    S_RESP    = 2'b10
  } wr_state_e;

endpackage

// File: rtl/axil_chan_capture.sv
// One-entry valid/ready holding register for a single AXI channel.
// Ready is high only while empty and out of reset; once a beat is
// captured the entry stays full until the owner pulses clear.
module axil_chan_capture #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             in_fire,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready = !full_q && !rst;
  assign in_fire  = in_valid && in_ready;
  assign full     = full_q;
  assign data     = data_q;

  // Next entry state: clear empties it, a handshake fills it.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear) begin
      full_d = 1'b0;
    end
    if (in_fire) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // Entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axil_write_ctrl_slave.sv
// AXI4-Lite slave write controller: joins AW and W, issues one register
// write strobe, then presents the B response until BREADY.
module axil_write_ctrl_slave
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic                      reg_wr_en,
  output logic [ADDR_WIDTH-3:0]     reg_wr_addr,
  output logic [DATA_WIDTH-1:0]     reg_wr_data,
  output logic [DATA_WIDTH/8-1:0]   reg_wr_strb
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned WPAY_W = STRB_W + DATA_WIDTH;

  // Reset is active-high on this port despite its name.
  logic rst;
  assign rst = ARESETn;

  logic                  aw_full, aw_hs;
  logic                  w_full, w_hs;
  logic                  chan_clear;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [WPAY_W-1:0]     w_payload;

  axil_chan_capture #(.WIDTH(ADDR_WIDTH)) u_aw_capture (
    .clk      (ACLK),
    .rst      (rst),
    .in_valid (AWVALID),
    .in_data  (AWADDR),
    .in_ready (AWREADY),
    .in_fire  (aw_hs),
    .clear    (chan_clear),
    .full     (aw_full),
    .data     (aw_addr)
  );

  axil_chan_capture #(.WIDTH(WPAY_W)) u_w_capture (
    .clk      (ACLK),
    .rst      (rst),
    .in_valid (WVALID),
    .in_data  ({WSTRB, WDATA}),
    .in_ready (WREADY),
    .in_fire  (w_hs),
    .clear    (chan_clear),
    .full     (w_full),
    .data     (w_payload)
  );

  wr_state_e         state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [IDX_W-1:0]      idx_eff;
  logic [1:0]            resp_code;
  logic                  join_done;

  // Decode the address that will be held after this edge: the incoming
  // one on an AW handshake, otherwise the one already captured.
  always_comb begin
    addr_eff  = aw_hs ? AWADDR : aw_addr;
    idx_eff   = addr_eff[ADDR_WIDTH-1:2];
    resp_code = RESP_OKAY;
    if ((addr_eff[1:0] != 2'b00) || (32'(idx_eff) >= NUM_REGS)) begin
      resp_code = RESP_SLVERR;
    end
    join_done = (aw_full || aw_hs) && (w_full || w_hs);
  end

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    chan_clear = 1'b0;
    unique case (state_q)
      S_COLLECT: begin
        if (join_done) begin
          state_d = S_WRITE;
          bresp_d = resp_code;
          wr_en_d = (resp_code == RESP_OKAY);
        end
      end
      S_WRITE: begin
        state_d  = S_RESP;
        bvalid_d = 1'b1;
      end
      S_RESP: begin
        if (BREADY) begin
          state_d    = S_COLLECT;
          bvalid_d   = 1'b0;
          chan_clear = 1'b1;
        end
      end
      default: begin
        state_d  = S_COLLECT;
        bvalid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (rst) begin
      state_q  <= S_COLLECT;
      wr_en_q  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      wr_en_q  <= wr_en_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  assign BVALID      = bvalid_q;
  assign BRESP       = bresp_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = aw_addr[ADDR_WIDTH-1:2];
  assign reg_wr_data = w_payload[DATA_WIDTH-1:0];
  assign reg_wr_strb = w_payload[WPAY_W-1:DATA_WIDTH];

endmodule

// File: tb/tb_axil_write_ctrl_slave.sv
// Scoreboard bench for axil_write_ctrl_slave: stimulus pushes expected
// register writes and B responses; a monitor pops and compares them.
module tb_axil_write_ctrl_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic [7:0]  AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic        reg_wr_en;
  logic [5:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t        exp_wr[$];
  logic [1:0] exp_b[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  axil_write_ctrl_slave #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .NUM_REGS   (16)
  ) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .AWADDR      (AWADDR),
    .AWVALID     (AWVALID),
    .AWREADY     (AWREADY),
    .WDATA       (WDATA),
    .WSTRB       (WSTRB),
    .WVALID      (WVALID),
    .WREADY      (WREADY),
    .BRESP       (BRESP),
    .BVALID      (BVALID),
    .BREADY      (BREADY),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Present AW and W together; returns #1 after the edge completing both.
  task automatic send(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] exp_resp, input bit push_b);
    bit ad = 0;
    bit wd = 0;
    bit af, wf;
    int n = 0;
    wr_t e;
    if (exp_resp == 2'b00) begin
      e.addr = a[7:2];
      e.data = d;
      e.strb = s;
      exp_wr.push_back(e);
    end
    if (push_b) exp_b.push_back(exp_resp);
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1;
    while (!(ad && wd)) begin
      if (n == 40) begin
        check("send_timeout", 64'd0, 64'd1);
        AWVALID = 1'b0; WVALID = 1'b0;
        return;
      end
      af = AWVALID && AWREADY;
      wf = WVALID && WREADY;
      tick();
      n++;
      if (af) begin ad = 1; AWVALID = 1'b0; end
      if (wf) begin wd = 1; WVALID = 1'b0; end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(AWREADY && WREADY && !BVALID)) begin
      if (n == 20) begin
        check("idle_timeout", 64'd0, 64'd1);
        return;
      end
      tick();
      n++;
    end
  endtask

  // Monitor: compare every write strobe and every B handshake against the queues.
  initial begin
    wr_t e;
    logic [1:0] r;
    forever begin
      @(negedge ACLK);
      if (reg_wr_en) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(reg_wr_addr), 64'(e.addr));
          check("wr_data", 64'(reg_wr_data), 64'(e.data));
          check("wr_strb", 64'(reg_wr_strb), 64'(e.strb));
        end
      end
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) check("b_unexpected", 64'd1, 64'd0);
        else begin
          r = exp_b.pop_front();
          check("bresp", 64'(BRESP), 64'(r));
        end
      end
    end
  end

  initial begin
    int prev;

    // Reset state while reset is held.
    ARESETn = 1'b1;
    repeat (3) tick();
    check("rst_awready", 64'(AWREADY), 64'd0);
    check("rst_wready", 64'(WREADY), 64'd0);
    check("rst_bvalid", 64'(BVALID), 64'd0);
    check("rst_bresp", 64'(BRESP), 64'd0);
    check("rst_wr_en", 64'(reg_wr_en), 64'd0);
    check("rst_wr_addr", 64'(reg_wr_addr), 64'd0);
    check("rst_wr_data", 64'(reg_wr_data), 64'd0);
    check("rst_wr_strb", 64'(reg_wr_strb), 64'd0);
    ARESETn = 1'b0;
    tick();
    check("idle_awready", 64'(AWREADY), 64'd1);
    check("idle_wready", 64'(WREADY), 64'd1);

    // 1: simultaneous AW/W, full latency profile.
    BREADY = 1'b1;
    send(8'h08, 32'hDEADBEEF, 4'hF, 2'b00, 1);
    check("t1_wr_en", 64'(reg_wr_en), 64'd1);
    check("t1_wr_addr", 64'(reg_wr_addr), 64'd2);
    check("t1_awready_write", 64'(AWREADY), 64'd0);
    check("t1_bvalid_write", 64'(BVALID), 64'd0);
    tick();
    check("t1_bvalid", 64'(BVALID), 64'd1);
    check("t1_bresp", 64'(BRESP), 64'd0);
    check("t1_wr_en_drop", 64'(reg_wr_en), 64'd0);
    tick();
    check("t1_bvalid_clr", 64'(BVALID), 64'd0);
    check("t1_awready_back", 64'(AWREADY), 64'd1);
    check("t1_wready_back", 64'(WREADY), 64'd1);

    // 2: W first, AW five cycles later.
    exp_wr.push_back('{addr: 6'd1, data: 32'h12345678, strb: 4'hF});
    exp_b.push_back(2'b00);
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("t2_wready_held", 64'(WREADY), 64'd0);
    check("t2_awready_open", 64'(AWREADY), 64'd1);
    repeat (4) tick();
    check("t2_wready_wait", 64'(WREADY), 64'd0);
    check("t2_awready_wait", 64'(AWREADY), 64'd1);
    check("t2_no_early_wr", 64'(reg_wr_en), 64'd0);
    AWADDR = 8'h04; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("t2_wr_en", 64'(reg_wr_en), 64'd1);
    check("t2_wr_addr", 64'(reg_wr_addr), 64'd1);
    wait_idle();

    // 3: out-of-range and misaligned addresses give SLVERR, no write.
    send(8'h40, 32'h11111111, 4'hF, 2'b10, 1);
    check("t3_oor_no_wr", 64'(reg_wr_en), 64'd0);
    wait_idle();
    send(8'h05, 32'h22222222, 4'hF, 2'b10, 1);
    check("t3_mis_no_wr", 64'(reg_wr_en), 64'd0);
    wait_idle();

    // 4: BREADY held low; response stable, new beats blocked.
    BREADY = 1'b0;
    send(8'h0C, 32'hCAFEF00D, 4'h3, 2'b00, 1);
    tick();
    AWADDR = 8'h10; WDATA = 32'h0BADF00D; WSTRB = 4'hC;
    AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t4_bvalid_hold", 64'(BVALID), 64'd1);
      check("t4_bresp_hold", 64'(BRESP), 64'd0);
      check("t4_awready_blk", 64'(AWREADY), 64'd0);
      check("t4_wready_blk", 64'(WREADY), 64'd0);
      tick();
    end
    BREADY = 1'b1;
    send(8'h10, 32'h0BADF00D, 4'hC, 2'b00, 1);
    check("t4_new_wr_en", 64'(reg_wr_en), 64'd1);
    wait_idle();

    // 5: reset during WRITE, then during RESP.
    BREADY = 1'b0;
    send(8'h14, 32'hA5A5A5A5, 4'hF, 2'b00, 0);
    ARESETn = 1'b1;
    tick();
    check("t5w_wr_en", 64'(reg_wr_en), 64'd0);
    check("t5w_bvalid", 64'(BVALID), 64'd0);
    check("t5w_wr_data", 64'(reg_wr_data), 64'd0);
    check("t5w_awready", 64'(AWREADY), 64'd0);
    ARESETn = 1'b0;
    tick();
    check("t5w_bvalid_after", 64'(BVALID), 64'd0);
    check("t5w_awready_after", 64'(AWREADY), 64'd1);
    send(8'h18, 32'h5A5A5A5A, 4'hF, 2'b00, 0);
    tick();
    check("t5r_bvalid_pre", 64'(BVALID), 64'd1);
    ARESETn = 1'b1;
    tick();
    check("t5r_bvalid", 64'(BVALID), 64'd0);
    check("t5r_wr_addr", 64'(reg_wr_addr), 64'd0);
    ARESETn = 1'b0;
    tick();
    check("t5r_bvalid_after", 64'(BVALID), 64'd0);
    BREADY = 1'b1;
    send(8'h1C, 32'h0F0F0F0F, 4'hF, 2'b00, 1);
    wait_idle();

    // Zero strobe still pulses the write.
    send(8'h20, 32'h00000055, 4'h0, 2'b00, 1);
    check("strb0_wr_en", 64'(reg_wr_en), 64'd1);
    wait_idle();

    // 6: eight back-to-back writes, one every 3 cycles.
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      send(8'(i * 4), 32'hA0000000 + 32'(i), 4'hF, 2'b00, 1);
      check("t6_wr_en", 64'(reg_wr_en), 64'd1);
      if (i > 0) check("t6_spacing", 64'(cyc - prev), 64'd3);
      prev = cyc;
    end
    wait_idle();
    repeat (2) tick();
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
